// File: rtl/alu_seq_ctrl_if.sv
// Bundle between the execute sequencer (master) and its instruction source,
// register file and ALU (slave).
interface alu_seq_ctrl_if #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4,
  parameter int FLAG_W  = 5
);
  logic                instr_valid;
  logic [DATA_W-1:0]   instr;
  logic                instr_ready;
  logic [RADDR_W-1:0]  rf_ra_addr;
  logic [RADDR_W-1:0]  rf_rb_addr;
  logic [DATA_W-1:0]   rf_ra_data;
  logic [DATA_W-1:0]   rf_rb_data;
  logic [7:0]          alu_op;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_c;
  logic [FLAG_W-1:0]   alu_flags;
  logic                rf_wr_en;
  logic [RADDR_W-1:0]  rf_wr_addr;
  logic [DATA_W-1:0]   rf_wr_data;
  logic [FLAG_W-1:0]   psr;
  logic                done;
  logic                illegal;

  modport master (
    input  instr_valid, instr, rf_ra_data, rf_rb_data, alu_c, alu_flags,
    output instr_ready, rf_ra_addr, rf_rb_addr, alu_op, alu_a, alu_b,
           rf_wr_en, rf_wr_addr, rf_wr_data, psr, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_ra_data, rf_rb_data, alu_c, alu_flags,
    input  instr_ready, rf_ra_addr, rf_rb_addr, alu_op, alu_a, alu_b,
           rf_wr_en, rf_wr_addr, rf_wr_data, psr, done, illegal
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Execute controller for register/immediate ALU instructions: READ, EXEC, WB
// over a sync-read register file and a combinational ALU, one instr per 4 cycles.
module alu_seq_ctrl #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4,
  parameter int FLAG_W  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_seq_ctrl_if.master  bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state, nxt;
  logic [DATA_W-1:0]   instr_q, alu_a_q, alu_b_q;
  logic [7:0]          alu_op_q;
  logic [FLAG_W-1:0]   psr_q;
  logic                ready, done, wr_en, ill;
  logic [3:0]          op, ext;
  logic                legal, r_type, psr_upd, is_cmp;

  assign op     = instr_q[15:12];
  assign ext    = instr_q[7:4];
  assign is_cmp = (op == 4'h0 && ext == 4'hB) || (op == 4'hB);

  // Opcode decode: legality, register-vs-immediate B operand, flag-writing ops.
  always_comb begin
    legal   = 1'b0;
    r_type  = 1'b0;
    psr_upd = 1'b0;
    case (op)
      4'h0: begin
        r_type = 1'b1;
        case (ext)
          4'h1, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB: begin legal = 1'b1; psr_upd = 1'b1; end
          4'h2, 4'h3, 4'h6, 4'hD:             legal = 1'b1;
          default: ;
        endcase
      end
      4'h8: begin
        case (ext)
          4'h0, 4'h1, 4'h2, 4'h3: legal = 1'b1;
          4'h4, 4'h6:             begin legal = 1'b1; r_type = 1'b1; end
          default: ;
        endcase
      end
      4'h1, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB: begin legal = 1'b1; psr_upd = 1'b1; end
      4'h2, 4'h3, 4'h6, 4'hD, 4'hF:       legal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      instr_q  <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      psr_q    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.instr_valid)
        instr_q <= bus.instr;
      if (state == EXEC) begin
        alu_op_q <= {op, ext};
        alu_a_q  <= bus.rf_ra_data;
        alu_b_q  <= r_type ? bus.rf_rb_data : {{(DATA_W-8){1'b0}}, instr_q[7:0]};
      end
      if (state == WB && legal && psr_upd)
        psr_q <= bus.alu_flags;
    end
  end

  always_comb begin
    nxt   = state;
    ready = 1'b0;
    done  = 1'b0;
    wr_en = 1'b0;
    ill   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) nxt = READ;
      end
      READ: nxt = EXEC;
      EXEC: nxt = WB;
      WB: begin
        done  = 1'b1;
        ill   = ~legal;
        wr_en = legal & ~is_cmp;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Register addresses come straight from the captured instruction, so they
  // stay stable from READ through WB.
  assign bus.instr_ready = ready;
  assign bus.rf_ra_addr  = instr_q[8 +: RADDR_W];
  assign bus.rf_rb_addr  = instr_q[0 +: RADDR_W];
  assign bus.rf_wr_addr  = instr_q[8 +: RADDR_W];
  assign bus.rf_wr_data  = bus.alu_c;
  assign bus.rf_wr_en    = wr_en;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.psr         = psr_q;
  assign bus.done        = done;
  assign bus.illegal     = ill;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: table of instructions with scoreboarded WB results,
// plus back-to-back issue and mid-instruction reset sequences.
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.DATA_W(16), .RADDR_W(4), .FLAG_W(5)) bus ();
  alu_seq_ctrl #(.DATA_W(16), .RADDR_W(4), .FLAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] ra, rb, c;
    logic [4:0]  fl;
    logic        wr, ill, upd;
    logic [15:0] b;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        ill;
    logic [7:0]  op;
    logic [15:0] a, b;
    logic [4:0]  psr;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [4:0]  psr_m;
  logic [15:0] rf [16];
  logic [15:0] cur_c;
  logic [4:0]  cur_fl;
  vec_t vt [14];
  logic        psr_pend = 1'b0;
  logic [4:0]  pend_psr;

  // Register file model with one-cycle read latency; ALU returns table values.
  always @(posedge clk) begin
    bus.rf_ra_data <= rf[bus.rf_ra_addr];
    bus.rf_rb_data <= rf[bus.rf_rb_addr];
  end
  assign bus.alu_c     = cur_c;
  assign bus.alu_flags = cur_fl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Retire monitor: pops the scoreboard on done and checks PSR one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (psr_pend) begin
      chk("psr_after_wb", {27'd0, bus.psr}, {27'd0, pend_psr});
      psr_pend = 1'b0;
    end
    if (bus.rf_wr_en)
      chk("wr_en_only_with_done", {31'd0, bus.done}, 32'd1);
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no retire at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("wr_en",   {31'd0, bus.rf_wr_en}, {31'd0, e.wr});
        if (e.wr) begin
          chk("wr_addr", {28'd0, bus.rf_wr_addr}, {28'd0, e.addr});
          chk("wr_data", {16'd0, bus.rf_wr_data}, {16'd0, e.data});
        end
        chk("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
        chk("alu_op",  {24'd0, bus.alu_op}, {24'd0, e.op});
        chk("alu_a",   {16'd0, bus.alu_a}, {16'd0, e.a});
        chk("alu_b",   {16'd0, bus.alu_b}, {16'd0, e.b});
        pend_psr = e.psr;
        psr_pend = 1'b1;
      end
    end
  end

  task automatic load(input vec_t v);
    rf[v.instr[11:8]] = v.ra;
    if (v.instr[3:0] != v.instr[11:8]) rf[v.instr[3:0]] = v.rb;
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    if (v.upd) psr_m = v.fl;
    e.wr = v.wr; e.addr = v.instr[11:8]; e.data = v.c; e.ill = v.ill;
    e.op = {v.instr[15:12], v.instr[7:4]}; e.a = v.ra; e.b = v.b; e.psr = psr_m;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    load(v);
    cur_c = v.c; cur_fl = v.fl;
    @(negedge clk);
    chk("ready_before", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr_valid = 1'b1; bus.instr = v.instr;
    push(v);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("done_timing", {31'd0, bus.done}, {31'd0, (k == 3)});
      chk("ready_busy", {31'd0, bus.instr_ready}, 32'd0);
    end
    @(negedge clk);
    chk("ready_back", {31'd0, bus.instr_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            instr     ra        rb        c         fl     wr    ill   upd   b
    vt[0]  = '{16'h0152, 16'h7FFF, 16'h0001, 16'h8000, 5'h04, 1'b1, 1'b0, 1'b1, 16'h0001};
    vt[1]  = '{16'hD5FF, 16'h1234, 16'h5555, 16'h00FF, 5'h13, 1'b1, 1'b0, 1'b0, 16'h00FF};
    vt[2]  = '{16'h03B4, 16'h0005, 16'h0007, 16'hFFFE, 5'h09, 1'b0, 1'b0, 1'b1, 16'h0007};
    vt[3]  = '{16'h01F0, 16'h2222, 16'h3333, 16'hAAAA, 5'h1F, 1'b0, 1'b1, 1'b0, 16'h3333};
    vt[4]  = '{16'h4123, 16'h4444, 16'h6666, 16'hBBBB, 5'h1F, 1'b0, 1'b1, 1'b0, 16'h0023};
    vt[5]  = '{16'hC1FF, 16'h0001, 16'h0002, 16'hCCCC, 5'h1F, 1'b0, 1'b1, 1'b0, 16'h00FF};
    vt[6]  = '{16'h5327, 16'h0100, 16'h9999, 16'h0127, 5'h10, 1'b1, 1'b0, 1'b1, 16'h0027};
    vt[7]  = '{16'h8446, 16'h0003, 16'h0002, 16'h000C, 5'h1F, 1'b1, 1'b0, 1'b0, 16'h0002};
    vt[8]  = '{16'h8412, 16'h00F0, 16'h7777, 16'h01E0, 5'h1F, 1'b1, 1'b0, 1'b0, 16'h0012};
    vt[9]  = '{16'h0111, 16'h0F0F, 16'h0F0F, 16'h0F0F, 5'h02, 1'b1, 1'b0, 1'b1, 16'h0F0F};
    vt[10] = '{16'hF7AB, 16'h0000, 16'h8888, 16'hAB00, 5'h1F, 1'b1, 1'b0, 1'b0, 16'h00AB};
    vt[11] = '{16'h8750, 16'h0005, 16'h0006, 16'hDDDD, 5'h1F, 1'b0, 1'b1, 1'b0, 16'h0050};
    vt[12] = '{16'hB9C3, 16'h00C3, 16'h1111, 16'h0000, 5'h08, 1'b0, 1'b0, 1'b1, 16'h00C3};
    vt[13] = '{16'h0D31, 16'h0009, 16'h4321, 16'h4321, 5'h1F, 1'b1, 1'b0, 1'b0, 16'h4321};

    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    psr_m = 5'h00; cur_c = 16'h0; cur_fl = 5'h0;
    rst_n = 1'b0; bus.instr_valid = 1'b0; bus.instr = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_psr",    {27'd0, bus.psr}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_wr_en",  {31'd0, bus.rf_wr_en}, 32'd0);
    chk("rst_alu_op", {24'd0, bus.alu_op}, 32'd0);
    chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 32'd0);
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // Back-to-back: valid stays high, second instruction accepted at cycle 4.
    load(vt[6]); load(vt[7]);
    cur_c = vt[6].c; cur_fl = vt[6].fl;
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = vt[6].instr;
    push(vt[6]);
    @(posedge clk); #1;
    bus.instr = vt[7].instr;
    push(vt[7]);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("b2b_done",  {31'd0, bus.done}, {31'd0, (k == 3 || k == 7)});
      chk("b2b_ready", {31'd0, bus.instr_ready}, {31'd0, (k == 4 || k == 8)});
      if (k == 4) begin cur_c = vt[7].c; cur_fl = vt[7].fl; end
      if (k == 5) bus.instr_valid = 1'b0;
    end
    chk("b2b_sb_drained", sb.size(), 32'd0);

    // Reset during EXEC drops the instruction and clears PSR.
    load(vt[0]);
    cur_c = vt[0].c; cur_fl = vt[0].fl;
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = vt[0].instr;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_psr",   {27'd0, bus.psr}, 32'd0);
    chk("midrst_wr_en", {31'd0, bus.rf_wr_en}, 32'd0);
    chk("midrst_done",  {31'd0, bus.done}, 32'd0);
    psr_m = 5'h00;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("midrst_done2", {31'd0, bus.done}, 32'd0);

    run_vec(vt[0]);
    @(negedge clk);
    chk("final_sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
